// File: rtl/e203_ifu_bhtbpu.sv
// IFU branch predictor: JAL/JALR always taken, Bxx predicted from a direct-mapped
// BHT of 2-bit saturating counters, plus JALR rs1 dependency and read-port handling.
module e203_ifu_bhtbpu #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int BHT_DEPTH   = 16,
  parameter int CNT_INIT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic                   dec_i_valid,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [XLEN-1:0]        dec_bjp_imm,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic                   oitf_empty,
  input  logic                   ir_empty,
  input  logic                   ir_rs1en,
  input  logic                   ir_valid_clr,
  input  logic                   jalr_rs1idx_cam_irrdidx,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  input  logic                   bht_upd_valid,
  input  logic [PC_SIZE-1:0]     bht_upd_pc,
  input  logic                   bht_upd_taken,
  input  logic                   bht_flush,
  output logic                   bpu_wait,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
  output logic                   bpu2rf_rs1_ena
);

  localparam int         IDX_W   = $clog2(BHT_DEPTH);
  localparam logic [1:0] CNT_RST = 2'(CNT_INIT);

  typedef enum logic {
    RD_IDLE,
    RD_RDRF
  } rd_state_e;

  rd_state_e            rd_state;
  logic                 rdrf_r;
  logic [1:0]           cnt [BHT_DEPTH];
  logic [BHT_DEPTH-1:0] vld;

  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_upd_pc;

  assign lkp_idx       = pc[IDX_W:1];
  assign upd_idx       = bht_upd_pc[IDX_W:1];
  assign unused_upd_pc = ^{bht_upd_pc[PC_SIZE-1:IDX_W+1], bht_upd_pc[0]};

  logic jalr_valid;
  logic rs1_x0;
  logic rs1_x1;
  logic rs1_xn;
  logic x1_dep;
  logic xn_dep;
  logic xn_waive;
  logic xn_dep_eff;
  logic rd_set;
  logic bxx_dir;

  assign jalr_valid = dec_i_valid & dec_jalr;
  assign rs1_x0     = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
  assign rs1_x1     = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
  assign rs1_xn     = ~rs1_x0 & ~rs1_x1;

  assign x1_dep     = jalr_valid & rs1_x1 & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
  assign xn_dep     = jalr_valid & rs1_xn & (~oitf_empty | ~ir_empty);
  // The IR instruction cannot disturb rs1 if it is leaving or never reads port 1.
  assign xn_waive   = oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);
  assign xn_dep_eff = xn_dep & ~xn_waive;

  assign rdrf_r = (rd_state == RD_RDRF);
  assign rd_set = ~rdrf_r & jalr_valid & rs1_xn & (~xn_dep | xn_waive);

  assign bpu_wait       = x1_dep | xn_dep_eff | rd_set;
  assign bpu2rf_rs1_ena = rd_set;

  // Invalid entries fall back to static backward-taken; no bypass of same-cycle updates.
  assign bxx_dir    = vld[lkp_idx] ? cnt[lkp_idx][1] : dec_bjp_imm[XLEN-1];
  assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bxx_dir);

  always_comb begin
    prdt_pc_add_op1 = '0;
    if (dec_bxx | dec_jal) begin
      prdt_pc_add_op1 = pc;
    end else if (rs1_x1) begin
      prdt_pc_add_op1 = rf2bpu_x1[PC_SIZE-1:0];
    end else if (rs1_xn) begin
      prdt_pc_add_op1 = rf2bpu_rs1[PC_SIZE-1:0];
    end
  end

  assign prdt_pc_add_op2 = dec_bjp_imm[PC_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
    end else begin
      case (rd_state)
        RD_IDLE: if (rd_set) rd_state <= RD_RDRF;
        RD_RDRF: rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // First update of an invalid entry seeds it weakly toward the observed outcome.
  always_ff @(posedge clk) begin
    if (!rst_n || bht_flush) begin
      vld <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        cnt[i] <= CNT_RST;
      end
    end else if (bht_upd_valid) begin
      if (!vld[upd_idx]) begin
        vld[upd_idx] <= 1'b1;
        cnt[upd_idx] <= bht_upd_taken ? 2'd2 : 2'd1;
      end else if (bht_upd_taken) begin
        if (cnt[upd_idx] != 2'd3) cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      end else begin
        if (cnt[upd_idx] != 2'd0) cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_e203_ifu_bhtbpu.sv
// Scoreboarded bench for e203_ifu_bhtbpu: directed scenarios then random traffic,
// all checked against a table-level model of the BHT and the JALR read rules.
module tb_e203_ifu_bhtbpu;

  localparam int DEPTH    = 16;
  localparam int CNT_INIT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
  logic [31:0] dec_bjp_imm;
  logic [4:0]  dec_jalr_rs1idx;
  logic        oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
  logic [31:0] rf2bpu_x1, rf2bpu_rs1;
  logic        bht_upd_valid;
  logic [31:0] bht_upd_pc;
  logic        bht_upd_taken, bht_flush;
  logic        bpu_wait, prdt_taken, bpu2rf_rs1_ena;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

  e203_ifu_bhtbpu dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .pc                      (pc),
    .dec_i_valid             (dec_i_valid),
    .dec_jal                 (dec_jal),
    .dec_jalr                (dec_jalr),
    .dec_bxx                 (dec_bxx),
    .dec_bjp_imm             (dec_bjp_imm),
    .dec_jalr_rs1idx         (dec_jalr_rs1idx),
    .oitf_empty              (oitf_empty),
    .ir_empty                (ir_empty),
    .ir_rs1en                (ir_rs1en),
    .ir_valid_clr            (ir_valid_clr),
    .jalr_rs1idx_cam_irrdidx (jalr_rs1idx_cam_irrdidx),
    .rf2bpu_x1               (rf2bpu_x1),
    .rf2bpu_rs1              (rf2bpu_rs1),
    .bht_upd_valid           (bht_upd_valid),
    .bht_upd_pc              (bht_upd_pc),
    .bht_upd_taken           (bht_upd_taken),
    .bht_flush               (bht_flush),
    .bpu_wait                (bpu_wait),
    .prdt_taken              (prdt_taken),
    .prdt_pc_add_op1         (prdt_pc_add_op1),
    .prdt_pc_add_op2         (prdt_pc_add_op2),
    .bpu2rf_rs1_ena          (bpu2rf_rs1_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        exp_wait;
    logic        exp_taken;
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
    logic        exp_ena;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: per-entry counter/valid table and "read issued last cycle" flag.
  int m_cnt [DEPTH];
  bit m_vld [DEPTH];
  bit m_rd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      m_cnt[i] = CNT_INIT;
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic computeExpected(input string name, output exp_t e, output bit set_o);
    int idx;
    bit dep, waived;
    idx         = (pc >> 1) % DEPTH;
    e.name      = name;
    e.exp_op2   = dec_bjp_imm;
    e.exp_taken = dec_jal || dec_jalr ||
                  (dec_bxx && (m_vld[idx] ? (m_cnt[idx] >= 2) : dec_bjp_imm[31]));
    if (dec_bxx || dec_jal)         e.exp_op1 = pc;
    else if (dec_jalr_rs1idx == 0)  e.exp_op1 = 32'h0;
    else if (dec_jalr_rs1idx == 1)  e.exp_op1 = rf2bpu_x1;
    else                            e.exp_op1 = rf2bpu_rs1;
    e.exp_wait = 1'b0;
    e.exp_ena  = 1'b0;
    set_o      = 1'b0;
    if (dec_i_valid && dec_jalr) begin
      if (dec_jalr_rs1idx == 1) begin
        e.exp_wait = !oitf_empty || jalr_rs1idx_cam_irrdidx;
      end else if (dec_jalr_rs1idx != 0) begin
        dep    = !oitf_empty || !ir_empty;
        waived = oitf_empty && !ir_empty && (ir_valid_clr || !ir_rs1en);
        if (m_rd) begin
          e.exp_wait = dep && !waived;
        end else if (dep && !waived) begin
          e.exp_wait = 1'b1;
        end else begin
          e.exp_wait = 1'b1;
          e.exp_ena  = 1'b1;
          set_o      = 1'b1;
        end
      end
    end
  endtask

  task automatic updateModel(input bit set_i);
    int ui;
    ui = (bht_upd_pc >> 1) % DEPTH;
    if (!rst_n || bht_flush) begin
      modelReset();
    end else if (bht_upd_valid) begin
      if (!m_vld[ui]) begin
        m_vld[ui] = 1'b1;
        m_cnt[ui] = bht_upd_taken ? 2 : 1;
      end else if (bht_upd_taken) begin
        m_cnt[ui] = (m_cnt[ui] + 1 > 3) ? 3 : m_cnt[ui] + 1;
      end else begin
        m_cnt[ui] = (m_cnt[ui] - 1 < 0) ? 0 : m_cnt[ui] - 1;
      end
    end
    m_rd = rst_n ? set_i : 1'b0;
  endtask

  // Queue the expectation for the current inputs, then let the clock edge apply them.
  task automatic applyStimulus(input string name);
    exp_t e;
    bit   s;
    computeExpected(name, e, s);
    exp_q.push_back(e);
    @(posedge clk);
    updateModel(s);
    #1;
  endtask

  task automatic setQuiet();
    rst_n = 1'b1;
    pc = 32'h100; dec_i_valid = 1'b0;
    dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0;
    dec_bjp_imm = 32'h0; dec_jalr_rs1idx = 5'd0;
    oitf_empty = 1'b1; ir_empty = 1'b1; ir_rs1en = 1'b0; ir_valid_clr = 1'b0;
    jalr_rs1idx_cam_irrdidx = 1'b0;
    rf2bpu_x1 = 32'h0; rf2bpu_rs1 = 32'h0;
    bht_upd_valid = 1'b0; bht_upd_pc = 32'h0; bht_upd_taken = 1'b0; bht_flush = 1'b0;
  endtask

  task automatic resetCycles(input int n);
    setQuiet();
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    modelReset();
    m_rd = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic lookupBxx(input logic [31:0] p, input logic [31:0] imm);
    dec_i_valid = 1'b1; dec_bxx = 1'b1; pc = p; dec_bjp_imm = imm;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_wait"},  {31'b0, bpu_wait},       {31'b0, e.exp_wait});
        checkOutput({e.name, "_taken"}, {31'b0, prdt_taken},     {31'b0, e.exp_taken});
        checkOutput({e.name, "_op1"},   prdt_pc_add_op1,         e.exp_op1);
        checkOutput({e.name, "_op2"},   prdt_pc_add_op2,         e.exp_op2);
        checkOutput({e.name, "_ena"},   {31'b0, bpu2rf_rs1_ena}, {31'b0, e.exp_ena});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    resetCycles(2);

    // Static backward-taken rule after reset.
    setQuiet(); lookupBxx(32'h200, 32'hFFFF_FFF8); #2;
    checkOutput("t1_back_taken", {31'b0, prdt_taken}, 32'h1);
    checkOutput("t1_op1", prdt_pc_add_op1, 32'h200);
    checkOutput("t1_op2", prdt_pc_add_op2, 32'hFFFF_FFF8);
    applyStimulus("t1_back");
    dec_bjp_imm = 32'h8; #2;
    checkOutput("t1_fwd_taken", {31'b0, prdt_taken}, 32'h0);
    applyStimulus("t1_fwd");

    // Train 0x104 to strongly taken, then one not-taken.
    setQuiet(); bht_upd_valid = 1'b1; bht_upd_pc = 32'h104; bht_upd_taken = 1'b1;
    repeat (3) applyStimulus("t2_train");
    bht_upd_valid = 1'b0; lookupBxx(32'h104, 32'h8); #2;
    checkOutput("t2_cnt3_taken", {31'b0, prdt_taken}, 32'h1);
    applyStimulus("t2_look3");
    bht_upd_valid = 1'b1; bht_upd_taken = 1'b0;
    applyStimulus("t2_nt_upd");
    bht_upd_valid = 1'b0; #2;
    checkOutput("t2_cnt2_taken", {31'b0, prdt_taken}, 32'h1);
    applyStimulus("t2_look2");

    // 0x124 aliases 0x104: drive to 0, then same-cycle update returns the old value.
    setQuiet(); bht_upd_valid = 1'b1; bht_upd_pc = 32'h124; bht_upd_taken = 1'b0;
    repeat (4) applyStimulus("t3_sat0");
    bht_upd_valid = 1'b0; lookupBxx(32'h104, 32'hFFFF_FFF8); #2;
    checkOutput("t3_cnt0_nt", {31'b0, prdt_taken}, 32'h0);
    applyStimulus("t3_look0");
    dec_bjp_imm = 32'h8; bht_upd_valid = 1'b1; bht_upd_pc = 32'h104; bht_upd_taken = 1'b1; #2;
    checkOutput("t3_same_cycle_old0", {31'b0, prdt_taken}, 32'h0);
    applyStimulus("t3_sc0");
    #2;
    checkOutput("t3_same_cycle_old1", {31'b0, prdt_taken}, 32'h0);
    applyStimulus("t3_sc1");
    bht_upd_valid = 1'b0; #2;
    checkOutput("t3_cnt2_visible", {31'b0, prdt_taken}, 32'h1);
    applyStimulus("t3_look2");
    bht_upd_valid = 1'b1; bht_upd_pc = 32'h124;
    repeat (4) applyStimulus("t3_sat3");
    bht_upd_taken = 1'b0;
    applyStimulus("t3_down");

    // JALR xN, no dependency: read cycle then operand cycle.
    setQuiet(); dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1idx = 5'd5;
    rf2bpu_rs1 = 32'hDEAD_BEEF; #2;
    checkOutput("t4_c0_wait", {31'b0, bpu_wait}, 32'h1);
    checkOutput("t4_c0_ena", {31'b0, bpu2rf_rs1_ena}, 32'h1);
    applyStimulus("t4_c0");
    #2;
    checkOutput("t4_c1_wait", {31'b0, bpu_wait}, 32'h0);
    checkOutput("t4_c1_op1", prdt_pc_add_op1, 32'hDEAD_BEEF);
    applyStimulus("t4_c1");
    setQuiet(); applyStimulus("t4_idle");

    // JALR x1 blocked by cam hit, then released.
    dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1idx = 5'd1;
    rf2bpu_x1 = 32'h1234_5678; jalr_rs1idx_cam_irrdidx = 1'b1;
    repeat (3) applyStimulus("t5_x1_dep");
    jalr_rs1idx_cam_irrdidx = 1'b0; #2;
    checkOutput("t5_x1_wait", {31'b0, bpu_wait}, 32'h0);
    checkOutput("t5_x1_op1", prdt_pc_add_op1, 32'h1234_5678);
    checkOutput("t5_x1_ena", {31'b0, bpu2rf_rs1_ena}, 32'h0);
    applyStimulus("t5_x1_go");
    dec_jalr_rs1idx = 5'd5; ir_empty = 1'b0; ir_rs1en = 1'b1;
    applyStimulus("t5_xn_blocked");
    ir_rs1en = 1'b0; #2;
    checkOutput("t5_waive_ena", {31'b0, bpu2rf_rs1_ena}, 32'h1);
    applyStimulus("t5_waive0");
    applyStimulus("t5_waive1");
    setQuiet(); applyStimulus("t5_idle");

    // Flush wins over a same-cycle update; lookups fall back to the static rule.
    bht_flush = 1'b1; bht_upd_valid = 1'b1; bht_upd_pc = 32'h104; bht_upd_taken = 1'b1;
    applyStimulus("t6_flush");
    setQuiet(); lookupBxx(32'h104, 32'h8); #2;
    checkOutput("t6_static_fwd", {31'b0, prdt_taken}, 32'h0);
    applyStimulus("t6_fwd");
    dec_bjp_imm = 32'hFFFF_FFF0;
    applyStimulus("t6_back");

    // Reset on the read-issue cycle suppresses RDRF, so the next cycle reissues.
    setQuiet(); dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1idx = 5'd7;
    rst_n = 1'b0;
    applyStimulus("t6_rst_set");
    rst_n = 1'b1; #2;
    checkOutput("t6_reissue_ena", {31'b0, bpu2rf_rs1_ena}, 32'h1);
    applyStimulus("t6_reissue");
    rst_n = 1'b0;
    applyStimulus("t6_rst_rdrf");
    rst_n = 1'b1;
    applyStimulus("t6_after_rst");
    setQuiet(); applyStimulus("t6_idle");

    // Random traffic over a small PC window so entries alias and saturate.
    for (int n = 0; n < 3000; n++) begin
      int cls, rsel;
      cls  = $urandom_range(0, 3);
      rsel = $urandom_range(0, 3);
      rst_n           = ($urandom_range(0, 127) != 0);
      dec_i_valid     = ($urandom_range(0, 3) != 0);
      dec_jal         = (cls == 1);
      dec_jalr        = (cls == 2);
      dec_bxx         = (cls == 3);
      pc              = 32'h100 + 32'($urandom_range(0, 63)) * 2;
      dec_bjp_imm     = $urandom();
      dec_jalr_rs1idx = (rsel == 0) ? 5'd0 : (rsel == 1) ? 5'd1 : 5'($urandom_range(2, 31));
      oitf_empty      = ($urandom_range(0, 3) != 0);
      ir_empty        = $urandom_range(0, 1) == 1;
      ir_rs1en        = $urandom_range(0, 1) == 1;
      ir_valid_clr    = $urandom_range(0, 1) == 1;
      jalr_rs1idx_cam_irrdidx = ($urandom_range(0, 2) == 0);
      rf2bpu_x1       = $urandom();
      rf2bpu_rs1      = $urandom();
      bht_upd_valid   = $urandom_range(0, 1) == 1;
      bht_upd_pc      = 32'h100 + 32'($urandom_range(0, 63)) * 2;
      bht_upd_taken   = $urandom_range(0, 1) == 1;
      bht_flush       = ($urandom_range(0, 63) == 0);
      applyStimulus("rnd");
    end

    setQuiet();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
